bus_master_port: RTL and testbench

- Master-side bus interface between a local host (parallel command/response) and the serial system bus.
- Takes one command at a time, raises the bus request, waits for grant, and serially shifts out slave ID, address and write data.
- For reads, collects serial read data from the slave; returns a one-cycle response pulse to the host.
- One instance per master (master 1 and master 2).

---
 rtl/bus_master_port.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_bus_master_port.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_port.sv
// bus_master_port: master-side port between a parallel host command/response
// interface and the serial system bus. It takes one command at a time,
// requests the bus and waits for the grant. It then shifts the slave ID,
// the address and any write data out LSB-first, one bit per clock. For a
// read it collects the serial read word. Every command ends with a one-cycle
// response pulse.
// Optional feature: define BUS_MASTER_TIMEOUT_EN to abandon the slave
// acknowledge / read-data waits after TIMEOUT_CYCLES cycles with an error.
// Without it the wait states hold until the slave answers or the grant is lost.
module bus_master_port #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int SLAVE_ID_WIDTH = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [SLAVE_ID_WIDTH-1:0] cmd_slave,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      m_request,
  input  logic                      m_grant,
  output logic                      m_sel,
  output logic                      m_wdata,
  output logic                      m_valid,
  output logic                      m_write,
  input  logic                      s_ready,
  input  logic                      s_rvalid,
  input  logic                      s_rdata
);

  localparam int MAX_AD = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int MAX_W  = (MAX_AD > SLAVE_ID_WIDTH) ? MAX_AD : SLAVE_ID_WIDTH;
  localparam int CNT_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    SEL,
    ADDR,
    WDATA,
    WAIT_ACK,
    WAIT_RD,
    RDATA,
    DONE
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic                      err_next;
  logic                      err_q;
  logic [CNT_W-1:0]          cnt;
  logic                      write_q;
  logic [SLAVE_ID_WIDTH-1:0] slave_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      accept;
  logic                      last_sel;
  logic                      last_addr;
  logic                      last_wdata;
  logic                      last_rbit;
  logic                      tmo_hit;

  assign accept     = (state == IDLE) && cmd_valid;
  assign last_sel   = (cnt == CNT_W'(SLAVE_ID_WIDTH - 1));
  assign last_addr  = (cnt == CNT_W'(ADDR_WIDTH - 1));
  assign last_wdata = (cnt == CNT_W'(DATA_WIDTH - 1));
  // Bit 0 of the read word is taken in WAIT_RD, so RDATA ends on bit DATA_WIDTH-1.
  assign last_rbit  = (cnt == CNT_W'(DATA_WIDTH - 2));

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Wait-state timer: restarts on every state change and runs only in the wait states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state_next != state) begin
      tmo_cnt <= '0;
    end else if ((state == WAIT_ACK) || (state == WAIT_RD)) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  // No timer in this build: a non-negative limit never fires, so waits hold.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, including grant loss, invalid slave ID and timeout errors.
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_slave[0]) begin
            state_next = REQ;
          end else begin
            state_next = DONE;
            err_next   = 1'b1;
          end
        end
      end
      REQ: begin
        if (m_grant) begin
          state_next = SEL;
        end
      end
      SEL: begin
        if (!m_grant) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else if (last_sel) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (!m_grant) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else if (last_addr) begin
          state_next = write_q ? WDATA : WAIT_RD;
        end
      end
      WDATA: begin
        if (!m_grant) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else if (last_wdata) begin
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!m_grant) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else if (s_ready) begin
          state_next = DONE;
        end else if (tmo_hit) begin
          state_next = DONE;
          err_next   = 1'b1;
        end
      end
      WAIT_RD: begin
        if (!m_grant) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else if (s_rvalid) begin
          state_next = (DATA_WIDTH > 1) ? RDATA : DONE;
        end else if (tmo_hit) begin
          state_next = DONE;
          err_next   = 1'b1;
        end
      end
      RDATA: begin
        if (!m_grant) begin
          state_next = DONE;
          err_next   = 1'b1;
        end else if (s_rvalid && last_rbit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Error flag, captured on the transition into DONE and cleared afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_next;
    end
  end

  // Bit counter: cleared on every state change, advanced per bit sent or received.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else if ((state == SEL) || (state == ADDR) || (state == WDATA) ||
                 ((state == RDATA) && s_rvalid)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Command latch and serialisers: fields shift right so bit 0 is always the next bit out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      slave_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= cmd_write;
      slave_q <= cmd_slave;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
    end else begin
      if (state == SEL) begin
        slave_q <= slave_q >> 1;
      end
      if (state == ADDR) begin
        addr_q <= addr_q >> 1;
      end
      if (state == WDATA) begin
        wdata_q <= wdata_q >> 1;
      end
    end
  end

  // Read deserialiser: bits enter at the MSB, so after DATA_WIDTH bits the first one sits at bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (accept) begin
      rdata_q <= '0;
    end else if (((state == WAIT_RD) || (state == RDATA)) && s_rvalid) begin
      rdata_q <= (rdata_q >> 1) | (DATA_WIDTH'(s_rdata) << (DATA_WIDTH - 1));
    end
  end

  // Moore outputs decoded from the state and the latched command.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    m_request = 1'b0;
    m_sel     = 1'b0;
    m_wdata   = 1'b0;
    m_valid   = 1'b0;
    m_write   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
      end
      REQ: begin
        m_request = 1'b1;
      end
      SEL: begin
        m_request = 1'b1;
        m_write   = write_q;
        m_sel     = slave_q[0];
      end
      ADDR: begin
        m_request = 1'b1;
        m_write   = write_q;
        m_valid   = 1'b1;
        m_wdata   = addr_q[0];
      end
      WDATA: begin
        m_request = 1'b1;
        m_write   = write_q;
        m_valid   = 1'b1;
        m_wdata   = wdata_q[0];
      end
      WAIT_ACK, WAIT_RD, RDATA: begin
        m_request = 1'b1;
        m_write   = write_q;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!err_q && !write_q) begin
          rsp_rdata = rdata_q;
        end
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Testbench for bus_master_port: directed scenarios with hand-computed
// expectations, then randomized host/arbiter/slave activity. Every cycle is
// compared against a transaction-level model that holds the remaining serial
// beats in a queue.
module tb_bus_master_port;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int SW  = 3;
  localparam int TMO = 64;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [SW-1:0] cmd_slave;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          m_request;
  logic          m_grant;
  logic          m_sel;
  logic          m_wdata;
  logic          m_valid;
  logic          m_write;
  logic          s_ready;
  logic          s_rvalid;
  logic          s_rdata;

  int checks   = 0;
  int failures = 0;
  int rsp_seen = 0;

  bus_master_port #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_ID_WIDTH(SW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_slave(cmd_slave), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_request(m_request), .m_grant(m_grant), .m_sel(m_sel),
    .m_wdata(m_wdata), .m_valid(m_valid), .m_write(m_write),
    .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the bench itself wedges.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] outVec();
    return {cmd_ready, rsp_valid, rsp_err, rsp_rdata, m_request, m_sel, m_wdata, m_valid, m_write};
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic sel;
    logic valid;
    logic wdata;
  } beat_t;

  beat_t         beats[$];
  bit            busy;
  bit            granted;
  bit            resp_due;
  bit            resp_err_m;
  bit            wr_m;
  logic [DW-1:0] resp_data_m;
  logic [DW-1:0] rword_m;
  int            nbits;
  int            waitcnt;

  function automatic void modelClear();
    beats.delete();
    busy     = 0;
    granted  = 0;
    resp_due = 0;
    resp_err_m  = 0;
    resp_data_m = '0;
    nbits    = 0;
    waitcnt  = 0;
  endfunction

  function automatic void modelFinish(input bit err, input logic [DW-1:0] data);
    busy        = 0;
    resp_due    = 1;
    resp_err_m  = err;
    resp_data_m = err ? '0 : data;
  endfunction

  function automatic void modelWaitNoEvent();
`ifdef BUS_MASTER_TIMEOUT_EN
    if (waitcnt == TMO - 1) modelFinish(1, '0);
    else waitcnt++;
`endif
  endfunction

  function automatic void modelAccept();
    beat_t b;
    beats.delete();
    wr_m    = cmd_write;
    nbits   = 0;
    waitcnt = 0;
    rword_m = '0;
    if (!cmd_slave[0]) begin
      modelFinish(1, '0);
      return;
    end
    busy    = 1;
    granted = 0;
    for (int i = 0; i < SW; i++) begin b = '0; b.sel = cmd_slave[i]; beats.push_back(b); end
    for (int i = 0; i < AW; i++) begin b = '0; b.valid = 1; b.wdata = cmd_addr[i]; beats.push_back(b); end
    if (cmd_write)
      for (int i = 0; i < DW; i++) begin b = '0; b.valid = 1; b.wdata = cmd_wdata[i]; beats.push_back(b); end
  endfunction

  function automatic void modelStep();
    if (resp_due) begin
      resp_due = 0;
    end else if (!busy) begin
      if (cmd_valid) modelAccept();
    end else if (!granted) begin
      if (m_grant) granted = 1;
    end else if (!m_grant) begin
      modelFinish(1, '0);
    end else if (beats.size() > 0) begin
      void'(beats.pop_front());
    end else if (wr_m) begin
      if (s_ready) modelFinish(0, '0);
      else modelWaitNoEvent();
    end else begin
      if (s_rvalid) begin
        rword_m[nbits] = s_rdata;
        nbits++;
        if (nbits == DW) modelFinish(0, rword_m);
      end else if (nbits == 0) begin
        modelWaitNoEvent();
      end
    end
  endfunction

  function automatic logic [15:0] expectedOut();
    beat_t h;
    h = '0;
    if (busy && granted && beats.size() > 0) h = beats[0];
    return {!busy && !resp_due, resp_due, resp_due && resp_err_m,
            resp_due ? resp_data_m : 8'h00, busy, h.sel, h.wdata, h.valid,
            busy && granted && wr_m};
  endfunction

  // Compare process: advance the model at each edge, check every output mid-cycle.
  initial begin
    modelClear();
    forever begin
      @(posedge clk);
      if (reset) modelClear();
      else modelStep();
      @(negedge clk);
      if (reset) modelClear();
      if (rsp_valid) rsp_seen++;
      checkOutput("cycle_outputs", {16'h0, outVec()}, {16'h0, expectedOut()});
    end
  end

  // ---------------- directed stimulus with trace ----------------
  logic          tr_sel   [0:127];
  logic          tr_valid [0:127];
  logic          tr_wdata [0:127];
  logic          tr_req   [0:127];
  logic          tr_rv    [0:127];
  logic          tr_err   [0:127];
  logic          tr_ready [0:127];
  logic [DW-1:0] tr_rdata [0:127];

  function automatic int firstRsp(input int n);
    for (int t = 0; t <= n; t++) if (tr_rv[t]) return t;
    return -1;
  endfunction

  // Offers one command; cycle 0 is the acceptance cycle. Grant is high from
  // grant_tick until drop_tick; read bits are offered from rstart, skipping gap_at.
  task automatic applyStimulus(input logic wr, input logic [SW-1:0] slave,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input int grant_tick, input int drop_tick,
                               input logic [DW-1:0] rword, input int rstart,
                               input int gap_at, input int ncycles);
    int guard;
    int bitidx;
    guard  = 0;
    bitidx = 0;
    while (!cmd_ready && guard < 200) begin
      tick();
      guard++;
    end
    checkOutput("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1;
    cmd_write = wr;
    cmd_slave = slave;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    for (int t = 0; t <= ncycles; t++) begin
      if (t > 0) begin
        tick();
        cmd_valid = 0;
      end
      tr_sel[t]   = m_sel;
      tr_valid[t] = m_valid;
      tr_wdata[t] = m_wdata;
      tr_req[t]   = m_request;
      tr_rv[t]    = rsp_valid;
      tr_err[t]   = rsp_err;
      tr_ready[t] = cmd_ready;
      tr_rdata[t] = rsp_rdata;
      m_grant = (t >= grant_tick) && ((drop_tick < 0) || (t < drop_tick));
      s_ready = 1;
      if (!wr && t >= rstart && t != gap_at && bitidx < DW) begin
        s_rvalid = 1;
        s_rdata  = rword[bitidx];
        bitidx++;
      end else begin
        s_rvalid = 0;
        s_rdata  = 0;
      end
    end
  endtask

  task automatic pulseReset();
    reset = 1;
    #1;
    checkOutput("reset_outputs", {16'h0, outVec()}, 32'h8000);
    tick();
    tick();
    reset = 0;
  endtask

  logic [19:0] vbits;
  int          nv;
  int          reqs;

  initial begin
    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_slave = '0; cmd_addr = '0;
    cmd_wdata = '0; m_grant = 0; s_ready = 0; s_rvalid = 0; s_rdata = 0;
    tick();
    tick();
    checkOutput("reset_state", {16'h0, outVec()}, 32'h8000);
    reset = 0;
    tick();

    // Write 3'b101 / 12'hA5C / 8'h3C, immediate grant and ack.
    applyStimulus(1, 3'b101, 12'hA5C, 8'h3C, 0, -1, 8'h00, 1000, -1, 30);
    vbits = '0;
    nv = 0;
    for (int t = 0; t <= 30; t++) if (tr_valid[t]) begin
      if (nv < 20) vbits[nv] = tr_wdata[t];
      nv++;
    end
    checkOutput("wr_sel_bits", {29'h0, tr_sel[4], tr_sel[3], tr_sel[2]}, 32'h5);
    checkOutput("wr_valid_count", nv, 20);
    checkOutput("wr_serial_bits", {12'h0, vbits}, 32'h3CA5C);
    checkOutput("wr_latency", firstRsp(30), 26);
    checkOutput("wr_err", tr_err[26], 0);

    // Read 3'b011 returning 8'hB2 with one stall cycle mid-word (WAIT_RD starts at cycle 17).
    applyStimulus(0, 3'b011, 12'h3F1, 8'h00, 0, -1, 8'hB2, 18, 22, 30);
    checkOutput("rd_latency", firstRsp(30), 27);
    checkOutput("rd_data", tr_rdata[27], 8'hB2);
    checkOutput("rd_err", tr_err[27], 0);

    // Grant from cycle 10, lost at ADDR bit 4 (cycle 18).
    applyStimulus(1, 3'b001, 12'h123, 8'h55, 10, 18, 8'h00, 1000, -1, 22);
    checkOutput("gl_req_held", tr_req[9], 1);
    checkOutput("gl_addr_bit4", {30'h0, tr_req[18], tr_valid[18]}, 32'h3);
    checkOutput("gl_req_falls", tr_req[19], 0);
    checkOutput("gl_rsp_err", {30'h0, tr_rv[19], tr_err[19]}, 32'h3);
    checkOutput("gl_ready_after", tr_ready[20], 1);

    // Invalid slave ID: error response in the second cycle counting the acceptance cycle.
    m_grant = 1;
    applyStimulus(1, 3'b010, 12'h0FF, 8'hAA, 0, -1, 8'h00, 1000, -1, 6);
    reqs = 0;
    for (int t = 0; t <= 6; t++) reqs += int'(tr_req[t]);
    checkOutput("inv_no_request", reqs, 0);
    checkOutput("inv_rsp_cycle", firstRsp(6), 1);
    checkOutput("inv_rsp_err", tr_err[1], 1);

    // Read whose slave never answers (WAIT_RD entered at cycle 17).
    applyStimulus(0, 3'b111, 12'h800, 8'h00, 0, -1, 8'h00, 1000, -1, 90);
`ifdef BUS_MASTER_TIMEOUT_EN
    checkOutput("tmo_rsp_cycle", firstRsp(90), 17 + TMO);
    checkOutput("tmo_rsp_err", tr_err[17 + TMO], 1);
    checkOutput("tmo_rsp_data", tr_rdata[17 + TMO], 0);
`else
    checkOutput("hang_no_rsp", firstRsp(90), -1);
    checkOutput("hang_still_waiting", {30'h0, tr_req[90], tr_ready[90]}, 32'h2);
`endif
    pulseReset();

    // Reset asserted during WDATA (cycle 20), then a normal write.
    applyStimulus(1, 3'b101, 12'h5A5, 8'hC3, 0, -1, 8'h00, 1000, -1, 20);
    checkOutput("rst_no_rsp_before", firstRsp(20), -1);
    pulseReset();
    applyStimulus(1, 3'b111, 12'hFFF, 8'h81, 0, -1, 8'h00, 1000, -1, 30);
    checkOutput("rst_recover_latency", firstRsp(30), 26);
    checkOutput("rst_recover_err", tr_err[26], 0);

    // Randomized host, arbiter and slave behaviour.
    rsp_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_slave = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) cmd_slave[0] = 1'b1;
      cmd_addr  = 12'($urandom);
      cmd_wdata = 8'($urandom);
      if (m_grant) m_grant = ($urandom_range(0, 99) != 0);
      else m_grant = ($urandom_range(0, 2) == 0);
      s_ready  = ($urandom_range(0, 3) == 0);
      s_rvalid = ($urandom_range(0, 3) != 0);
      s_rdata  = 1'($urandom_range(0, 1));
    end
    checkOutput("rand_activity", (rsp_seen > 20), 1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
